// File: rtl/alu_mul_unit.sv
// RV32IM execute unit: base-ISA ALU plus M-extension multiplier behind one opcode.
// Combinational result/zero outputs, with a registered copy of each for capture.
module alu_mul_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [3:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic        zero_flag_o,
    output logic [31:0] result_q_o,
    output logic        zero_q_o
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_SLT    = 4'b1000;
    localparam logic [3:0] OP_SLTU   = 4'b1001;
    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1101;
    localparam logic [3:0] OP_PASSB  = 4'b1110;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;
    logic        [31:0] alu_res;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] prod;
    logic        [31:0] mul_res;
    logic               is_mul;
    logic        [31:0] result_p1;
    logic               zero_p1;

    assign a_s   = operand_a_i;
    assign b_s   = operand_b_i;
    assign shamt = operand_b_i[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OP_ADD:   alu_res = operand_a_i + operand_b_i;
            OP_SUB:   alu_res = operand_a_i - operand_b_i;
            OP_AND:   alu_res = operand_a_i & operand_b_i;
            OP_OR:    alu_res = operand_a_i | operand_b_i;
            OP_XOR:   alu_res = operand_a_i ^ operand_b_i;
            OP_SLL:   alu_res = operand_a_i << shamt;
            OP_SRL:   alu_res = operand_a_i >> shamt;
            OP_SRA:   alu_res = a_s >>> shamt;
            OP_SLT:   alu_res = {31'd0, (a_s < b_s)};
            OP_SLTU:  alu_res = {31'd0, (operand_a_i < operand_b_i)};
            OP_PASSB: alu_res = operand_b_i;
            default:  alu_res = '0;
        endcase
    end

    // Operands are widened to 64 bits before the multiply so the high half is exact;
    // A is sign-extended for MULH/MULHSU, B only for MULH.
    always_comb begin
        mul_a = {32'd0, operand_a_i};
        mul_b = {32'd0, operand_b_i};
        if (alu_op_i == OP_MULH || alu_op_i == OP_MULHSU)
            mul_a = {{32{operand_a_i[31]}}, operand_a_i};
        if (alu_op_i == OP_MULH)
            mul_b = {{32{operand_b_i[31]}}, operand_b_i};
    end

    assign prod = mul_a * mul_b;

    always_comb begin
        mul_res = prod[63:32];
        if (alu_op_i == OP_MUL)
            mul_res = prod[31:0];
    end

    assign is_mul      = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_MULHU);
    assign result_o    = is_mul ? mul_res : alu_res;
    assign zero_flag_o = (result_o == 32'd0);

    // ---- stage boundary: capture register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            zero_p1   <= 1'b0;
        end else begin
            result_p1 <= result_o;
            zero_p1   <= zero_flag_o;
        end
    end

    assign result_q_o = result_p1;
    assign zero_q_o   = zero_p1;

endmodule

// File: tb/tb_alu_mul_unit.sv
// Self-checking bench for alu_mul_unit: directed RV32IM cases, reset behaviour,
// and randomized operations against an arithmetic reference model.
module tb_alu_mul_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [3:0]  alu_op_i;
    logic [31:0] result_o;
    logic        zero_flag_o;
    logic [31:0] result_q_o;
    logic        zero_q_o;

    int checks;
    int errors;

    alu_mul_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .alu_op_i   (alu_op_i),
        .result_o   (result_o),
        .zero_flag_o(zero_flag_o),
        .result_q_o (result_q_o),
        .zero_q_o   (zero_q_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the instruction semantics.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int              ia;
        int              ib;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        logic [31:0]     r;
        ia = a;
        ib = b;
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = ia >>> b[4:0];
            4'd8:  r = (ia < ib) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin up = ua * ub; r = up[31:0]; end
            4'd11: begin sp = longint'(ia) * longint'(ib); r = sp[63:32]; end
            4'd12: begin sp = longint'(ia) * longint'(ub); r = sp[63:32]; end
            4'd13: begin up = ua * ub; r = up[63:32]; end
            4'd14: r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one operation between edges, check combinational outputs, then the
    // registered copies after the next rising edge. exp comes from the caller.
    task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        alu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        check32({tag, "_res"}, result_o, exp);
        check1({tag, "_zero"}, zero_flag_o, exp == 32'd0);
        @(posedge clk);
        #1;
        check32({tag, "_resq"}, result_q_o, exp);
        check1({tag, "_zeroq"}, zero_q_o, exp == 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        alu_op_i    = 4'd0;
        operand_a_i = 32'd0;
        operand_b_i = 32'd0;

        // Reset state: registers cleared, combinational path still live.
        #1;
        check32("rst_resq", result_q_o, 32'd0);
        check1("rst_zeroq", zero_q_o, 1'b0);
        check32("rst_res_comb", result_o, 32'd0);
        check1("rst_zero_comb", zero_flag_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check32("rst_hold_resq", result_q_o, 32'd0);
        check1("rst_hold_zeroq", zero_q_o, 1'b0);
        #2 rst_n = 1'b1;

        // Directed: wrap, shifts, compares.
        apply("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        apply("sub_wrap", 4'd1, 32'h0000_0000, 32'd1, 32'hFFFF_FFFF);
        apply("srl", 4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        apply("sra", 4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        apply("sll", 4'd5, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000);
        apply("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);

        // Directed: multiply family.
        apply("mul_m2", 4'd10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        apply("mulh_m2", 4'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        apply("mulhsu_m2", 4'd12, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        apply("mulhu_m2", 4'd13, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002);
        apply("mul_ext", 4'd10, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        apply("mulh_ext", 4'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        apply("mulhu_ext", 4'd13, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        apply("mulhsu_ext", 4'd12, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);

        // Directed: PASSB and reserved opcode.
        apply("passb", 4'd14, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
        apply("reserved", 4'd15, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0000);

        // Register and asynchronous reset behaviour.
        apply("add_5_7", 4'd0, 32'd5, 32'd7, 32'h0000_000C);
        #2 rst_n = 1'b0;
        #1;
        check32("async_rst_resq", result_q_o, 32'd0);
        check1("async_rst_zeroq", zero_q_o, 1'b0);
        check32("async_rst_res_comb", result_o, 32'h0000_000C);
        check1("async_rst_zero_comb", zero_flag_o, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        check32("release_before_edge", result_q_o, 32'd0);
        @(posedge clk);
        #1;
        check32("release_reload_resq", result_q_o, 32'h0000_000C);
        check1("release_reload_zeroq", zero_q_o, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = a;
                3: a = 32'd0;
                default: ;
            endcase
            apply($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
